// File: rtl/score_display_if.sv
// Display-side bundle of the score display: game inputs in, multiplexed 7-segment drive out.
// The master side (game or bench) drives score/colision; the display block is the slave.
interface score_display_if;
  logic [5:0] score;
  logic       colision;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (output score, output colision, input an, input seg, input dp);
  modport slave  (input score, input colision, output an, output seg, output dp);
endinterface

// File: rtl/score_display.sv
// Four-digit multiplexed 7-segment score display: current score on digits 1:0, best score on 3:2.
// Binary-to-BCD is a sequential shift-add-3 over both values; current digits blink after a crash.
module score_display #(
  parameter int REFRESH_BITS = 16,
  parameter int BLINK_DIV    = 12500000
) (
  input  logic           clk,
  input  logic           reset2,
  score_display_if.slave disp
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;

  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_DIV - 1);

  conv_state_t             state, state_next;
  logic                    load, shift_en, commit;
  logic [5:0]              best;
  logic [5:0]              bin_cur, bin_best;
  logic [7:0]              bcd_cur, bcd_best;
  logic [2:0]              cnt;
  logic [11:0]             op_latched, last_conv;
  logic [3:0]              cur_units, cur_tens, best_units, best_tens;
  logic [REFRESH_BITS-1:0] refresh_cnt;
  logic [1:0]              sel;
  logic [BLINK_W-1:0]      blink_cnt;
  logic                    blink_on, blink_blank;
  logic [3:0]              digit_val;
  logic                    digit_blank;
  logic [6:0]              seg_next;
  logic [3:0]              an_q;
  logic [6:0]              seg_q;
  logic                    dp_q;

  function automatic logic [7:0] add3(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (r[3:0] >= 4'd5) r[3:0] = r[3:0] + 4'd3;
    if (r[7:4] >= 4'd5) r[7:4] = r[7:4] + 4'd3;
    return r;
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset2) begin
    if (!reset2)                best <= 6'd0;
    else if (disp.score > best) best <= disp.score;
  end

  always_ff @(posedge clk or negedge reset2) begin
    if (!reset2) state <= IDLE;
    else         state <= state_next;
  end

  // A new conversion starts only when either operand differs from the last one converted
  always_comb begin
    state_next = state;
    load       = 1'b0;
    shift_en   = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if ({disp.score, best} != last_conv) begin
          load       = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (cnt == 3'd5) state_next = DONE;
      end
      DONE: begin
        commit     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset2) begin
    if (!reset2) begin
      bin_cur    <= '0;
      bin_best   <= '0;
      bcd_cur    <= '0;
      bcd_best   <= '0;
      cnt        <= '0;
      op_latched <= '0;
      last_conv  <= '0;
      cur_units  <= '0;
      cur_tens   <= '0;
      best_units <= '0;
      best_tens  <= '0;
    end else if (load) begin
      bin_cur    <= disp.score;
      bin_best   <= best;
      bcd_cur    <= '0;
      bcd_best   <= '0;
      cnt        <= '0;
      op_latched <= {disp.score, best};
    end else if (shift_en) begin
      {bcd_cur, bin_cur}   <= {add3(bcd_cur), bin_cur} << 1;
      {bcd_best, bin_best} <= {add3(bcd_best), bin_best} << 1;
      cnt                  <= cnt + 3'd1;
    end else if (commit) begin
      cur_units  <= bcd_cur[3:0];
      cur_tens   <= bcd_cur[7:4];
      best_units <= bcd_best[3:0];
      best_tens  <= bcd_best[7:4];
      last_conv  <= op_latched;
    end
  end

  always_ff @(posedge clk or negedge reset2) begin
    if (!reset2) refresh_cnt <= '0;
    else         refresh_cnt <= refresh_cnt + 1'b1;
  end

  assign sel = refresh_cnt[REFRESH_BITS-1 -: 2];

  always_ff @(posedge clk or negedge reset2) begin
    if (!reset2) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (!disp.colision) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (blink_cnt == BLINK_MAX) begin
      blink_cnt <= '0;
      blink_on  <= ~blink_on;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Gating with colision makes the current digits reappear on the first refresh after a crash clears
  assign blink_blank = disp.colision & ~blink_on;

  always_comb begin
    digit_val   = cur_units;
    digit_blank = blink_blank;
    case (sel)
      2'd0: begin
        digit_val   = cur_units;
        digit_blank = blink_blank;
      end
      2'd1: begin
        digit_val   = cur_tens;
        digit_blank = blink_blank | (cur_tens == 4'd0);
      end
      2'd2: begin
        digit_val   = best_units;
        digit_blank = 1'b0;
      end
      default: begin
        digit_val   = best_tens;
        digit_blank = (best_tens == 4'd0);
      end
    endcase
    seg_next = digit_blank ? 7'h7F : seg_code(digit_val);
  end

  always_ff @(posedge clk or negedge reset2) begin
    if (!reset2) begin
      an_q  <= 4'b1111;
      seg_q <= 7'h7F;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= ~(4'b0001 << sel);
      seg_q <= seg_next;
      dp_q  <= (sel != 2'd2);
    end
  end

  assign disp.an  = an_q;
  assign disp.seg = seg_q;
  assign disp.dp  = dp_q;

endmodule
